// File: rtl/peripheral_spram_biu_master_tl.sv
// BIU-side initiator for the SPRAM path: executes fill/read-out block commands
// as a sequence of single beats, with at most one bus transaction outstanding.
module peripheral_spram_biu_master_tl #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned PLEN = 64,
    parameter int unsigned LENW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [PLEN-1:0] cmd_addr_i,
    input  logic [LENW-1:0] cmd_len_i,
    input  logic [XLEN-1:0] cmd_seed_i,
    input  logic [2:0]      cmd_prot_i,
    output logic            rd_valid_o,
    output logic [XLEN-1:0] rd_data_o,
    input  logic            rd_ready_i,
    output logic            done_o,
    output logic            err_o,
    output logic [LENW-1:0] beats_o,
    output logic            biu_stb_o,
    input  logic            biu_stb_ack_i,
    input  logic            biu_d_ack_i,
    output logic [PLEN-1:0] biu_adri_o,
    input  logic [PLEN-1:0] biu_adro_i,
    output logic [2:0]      biu_size_o,
    output logic [2:0]      biu_type_o,
    output logic [2:0]      biu_prot_o,
    output logic            biu_lock_o,
    output logic            biu_we_o,
    output logic [XLEN-1:0] biu_d_o,
    input  logic [XLEN-1:0] biu_q_i,
    input  logic            biu_ack_i,
    input  logic            biu_err_i
);

    localparam int unsigned BEAT_BYTES = XLEN / 8;
    localparam logic [2:0]  BIU_SIZE   = 3'($clog2(BEAT_BYTES));

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RESP  = 3'd2,
        S_RDOUT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PLEN-1:0] addr_q, addr_d;
    logic [LENW-1:0] len_q, len_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic [2:0]      prot_q, prot_d;
    logic            we_q, we_d;
    logic [LENW-1:0] beats_q, beats_d;
    logic            err_q, err_d;
    logic            ready_q, ready_d;
    logic            stb_q, stb_d;
    logic            rd_valid_q, rd_valid_d;
    logic            done_q, done_d;
    logic            take_ack;
    logic            next_beat;

    // Pipelined-bus side channels carry nothing this initiator needs.
    logic unused_c;
    assign unused_c = ^{biu_d_ack_i, biu_adro_i};

    // Next-state, datapath updates and registered-output decode.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        data_d    = data_q;
        rd_data_d = rd_data_q;
        prot_d    = prot_q;
        we_d      = we_q;
        beats_d   = beats_q;
        err_d     = err_q;
        take_ack  = 1'b0;
        next_beat = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ready_q && cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    len_d   = cmd_len_i;
                    data_d  = cmd_seed_i;
                    prot_d  = cmd_prot_i;
                    we_d    = cmd_we_i;
                    beats_d = '0;
                    err_d   = 1'b0;
                    state_d = (cmd_len_i == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (biu_stb_ack_i) begin
                    if (biu_err_i) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (biu_ack_i) begin
                        take_ack = 1'b1;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (biu_err_i) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (biu_ack_i) begin
                    take_ack = 1'b1;
                end
            end
            S_RDOUT: begin
                if (rd_ready_i) begin
                    next_beat = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A completed beat: writes move on, reads park the data for the consumer.
        if (take_ack) begin
            beats_d = beats_q + LENW'(1);
            if (we_q) begin
                next_beat = 1'b1;
            end else begin
                rd_data_d = biu_q_i;
                state_d   = S_RDOUT;
            end
        end

        // Either finish the block or step address/pattern for the next beat.
        if (next_beat) begin
            if (beats_d == len_q) begin
                state_d = S_DONE;
            end else begin
                addr_d  = addr_q + PLEN'(BEAT_BYTES);
                data_d  = data_q + XLEN'(1);
                state_d = S_REQ;
            end
        end

        ready_d    = (state_d == S_IDLE);
        stb_d      = (state_d == S_REQ);
        rd_valid_d = (state_d == S_RDOUT);
        done_d     = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            data_q     <= '0;
            rd_data_q  <= '0;
            prot_q     <= '0;
            we_q       <= 1'b0;
            beats_q    <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            stb_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            prot_q     <= prot_d;
            we_q       <= we_d;
            beats_q    <= beats_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            stb_q      <= stb_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign beats_o     = beats_q;
    assign biu_stb_o   = stb_q;
    assign biu_adri_o  = addr_q;
    assign biu_size_o  = BIU_SIZE;
    assign biu_type_o  = 3'd0;
    assign biu_prot_o  = prot_q;
    assign biu_lock_o  = 1'b0;
    assign biu_we_o    = we_q;
    assign biu_d_o     = data_q;

endmodule

// File: tb/tb_peripheral_spram_biu_master_tl.sv
// Directed bench for peripheral_spram_biu_master_tl with a single-cycle memory responder.
module tb_peripheral_spram_biu_master_tl;

    logic        clk;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [63:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [63:0] cmd_seed;
    logic [2:0]  cmd_prot;
    logic        rd_valid, rd_ready;
    logic [63:0] rd_data;
    logic        done, err;
    logic [15:0] beats;
    logic        biu_stb, biu_stb_ack, biu_d_ack;
    logic [63:0] biu_adri, biu_adro;
    logic [2:0]  biu_size, biu_type, biu_prot;
    logic        biu_lock, biu_we;
    logic [63:0] biu_d, biu_q;
    logic        biu_ack, biu_err;

    peripheral_spram_biu_master_tl dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_seed_i(cmd_seed), .cmd_prot_i(cmd_prot),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_ready_i(rd_ready),
        .done_o(done), .err_o(err), .beats_o(beats),
        .biu_stb_o(biu_stb), .biu_stb_ack_i(biu_stb_ack), .biu_d_ack_i(biu_d_ack),
        .biu_adri_o(biu_adri), .biu_adro_i(biu_adro), .biu_size_o(biu_size),
        .biu_type_o(biu_type), .biu_prot_o(biu_prot), .biu_lock_o(biu_lock),
        .biu_we_o(biu_we), .biu_d_o(biu_d), .biu_q_i(biu_q),
        .biu_ack_i(biu_ack), .biu_err_i(biu_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Responder / monitor state
    logic [63:0] mem [logic [63:0]];
    logic [63:0] wa_q[$];
    logic [63:0] wd_q[$];
    logic [63:0] rd_q[$];
    int          stb_cycles = 0;
    int          done_cnt   = 0;
    int          stb_acc    = 0;
    int          rd_cnt     = 0;
    int          err_at     = -1;
    int          hold_lim   = 1000000;
    int          stall_left = 0;
    int          stall_beat = -1;
    logic [63:0] stall_exp  = '0;
    int          stall_cyc  = 0;
    int          stall_bad  = 0;
    logic        pending    = 1'b0;
    int          p_idx      = 0;
    logic [63:0] p_addr     = '0;
    logic        p_we       = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Single-cycle responder: stb_ack on sight, ack/err the following cycle; read-side consumer.
    initial begin
        biu_stb_ack = 1'b0; biu_ack = 1'b0; biu_err = 1'b0; biu_q = '0;
        biu_d_ack = 1'b0; biu_adro = '0; rd_ready = 1'b1;
        forever begin
            @(negedge clk);
            biu_stb_ack = 1'b0; biu_ack = 1'b0; biu_err = 1'b0;
            if (biu_stb) stb_cycles++;
            if (done) done_cnt++;
            if (rst) begin
                pending = 1'b0;
            end else if (pending) begin
                pending = 1'b0;
                biu_ack = 1'b1;
                if (p_idx == err_at) biu_err = 1'b1;
                else if (!p_we) biu_q = mem.exists(p_addr) ? mem[p_addr] : 64'h0;
            end else if (biu_stb && stb_acc < hold_lim) begin
                biu_stb_ack = 1'b1;
                pending = 1'b1;
                p_idx = stb_acc;
                stb_acc++;
                p_addr = biu_adri;
                p_we = biu_we;
                if (biu_we) begin
                    mem[biu_adri] = biu_d;
                    wa_q.push_back(biu_adri);
                    wd_q.push_back(biu_d);
                end
            end
            if (rd_valid && stall_left > 0 && rd_cnt == stall_beat) begin
                rd_ready = 1'b0;
                stall_left--;
                stall_cyc++;
                if (rd_data !== stall_exp) stall_bad++;
                if (biu_stb) stall_bad++;
            end else begin
                rd_ready = 1'b1;
                if (rd_valid) begin
                    rd_q.push_back(rd_data);
                    rd_cnt++;
                end
            end
        end
    end

    task automatic start_cmd(input logic we, input logic [63:0] addr, input logic [15:0] len,
                             input logic [63:0] seed, input logic [2:0] prot);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 64'(cmd_ready), 64'd1);
        cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_seed = seed; cmd_prot = prot;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Cycles counted from the first negedge after acceptance (that negedge is 1).
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    initial begin
        int cyc;
        int wb, rb, db, sb, ab;
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
        cmd_len = '0; cmd_seed = '0; cmd_prot = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(cmd_ready), 64'd0);
        check("rst_stb", 64'(biu_stb), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_beats", 64'(beats), 64'd0);
        check("rst_rdvalid", 64'(rd_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(cmd_ready), 64'd1);

        // 1: fill 4 beats
        wb = wa_q.size(); db = done_cnt;
        start_cmd(1'b1, 64'h100, 16'd4, 64'hA0, 3'd2);
        check("t1_prot", 64'(biu_prot), 64'd2);
        check("t1_size", 64'(biu_size), 64'd3);
        wait_done(cyc);
        check("t1_cycles", 64'(cyc), 64'd9);
        repeat (2) @(negedge clk);
        check("t1_nwrites", 64'(wa_q.size() - wb), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), wa_q[wb+i], 64'h100 + 64'(8*i));
            check($sformatf("t1_data%0d", i), wd_q[wb+i], 64'hA0 + 64'(i));
        end
        check("t1_done_once", 64'(done_cnt - db), 64'd1);
        check("t1_beats", 64'(beats), 64'd4);
        check("t1_err", 64'(err), 64'd0);

        // 2: read back 4 beats
        rb = rd_q.size(); db = done_cnt;
        start_cmd(1'b0, 64'h100, 16'd4, 64'h0, 3'd0);
        wait_done(cyc);
        repeat (2) @(negedge clk);
        check("t2_nreads", 64'(rd_q.size() - rb), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_rd%0d", i), rd_q[rb+i], 64'hA0 + 64'(i));
        check("t2_done_once", 64'(done_cnt - db), 64'd1);
        check("t2_beats", 64'(beats), 64'd4);

        // 3: read 3 beats, consumer stalls 5 cycles on beat 1
        rb = rd_q.size(); stall_beat = rd_cnt + 1; stall_exp = 64'hA1;
        stall_cyc = 0; stall_bad = 0; stall_left = 5;
        start_cmd(1'b0, 64'h100, 16'd3, 64'h0, 3'd0);
        wait_done(cyc);
        repeat (2) @(negedge clk);
        check("t3_stall_cycles", 64'(stall_cyc), 64'd5);
        check("t3_stall_hold", 64'(stall_bad), 64'd0);
        check("t3_nreads", 64'(rd_q.size() - rb), 64'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("t3_rd%0d", i), rd_q[rb+i], 64'hA0 + 64'(i));

        // 4: error with ack on beat 2 of a 5-beat fill
        ab = stb_acc; db = done_cnt; err_at = stb_acc + 1;
        start_cmd(1'b1, 64'h400, 16'd5, 64'h10, 3'd0);
        wait_done(cyc);
        repeat (4) @(negedge clk);
        err_at = -1;
        check("t4_err", 64'(err), 64'd1);
        check("t4_beats", 64'(beats), 64'd1);
        check("t4_nstb", 64'(stb_acc - ab), 64'd2);
        check("t4_done_once", 64'(done_cnt - db), 64'd1);

        // 5a: zero-length command
        sb = stb_cycles; db = done_cnt;
        start_cmd(1'b1, 64'h500, 16'd0, 64'h0, 3'd0);
        wait_done(cyc);
        check("t5_done_latency_le2", 64'(cyc <= 2), 64'd1);
        repeat (3) @(negedge clk);
        check("t5_no_stb", 64'(stb_cycles - sb), 64'd0);
        check("t5_err_cleared", 64'(err), 64'd0);
        check("t5_beats", 64'(beats), 64'd0);
        check("t5_done_once", 64'(done_cnt - db), 64'd1);

        // 5b: address wraps at top of space
        wb = wa_q.size();
        start_cmd(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 16'd2, 64'h5, 3'd0);
        wait_done(cyc);
        repeat (2) @(negedge clk);
        check("t5_nwrites", 64'(wa_q.size() - wb), 64'd2);
        check("t5_addr0", wa_q[wb], 64'hFFFF_FFFF_FFFF_FFF8);
        check("t5_addr1_wrap", wa_q[wb+1], 64'h0);
        check("t5_data1", wd_q[wb+1], 64'h6);

        // 6: reset while stb waits for stb_ack on beat 1
        hold_lim = stb_acc + 1;
        start_cmd(1'b1, 64'h200, 16'd3, 64'h50, 3'd0);
        repeat (4) @(negedge clk);
        check("t6_stb_waiting", 64'(biu_stb), 64'd1);
        check("t6_addr_beat1", biu_adri, 64'h208);
        check("t6_beats_pre", 64'(beats), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_stb_dropped", 64'(biu_stb), 64'd0);
        check("t6_ready_in_rst", 64'(cmd_ready), 64'd0);
        check("t6_beats_clr", 64'(beats), 64'd0);
        check("t6_err_clr", 64'(err), 64'd0);
        rst = 1'b0;
        hold_lim = 1000000;
        @(negedge clk);
        check("t6_ready_after", 64'(cmd_ready), 64'd1);
        sb = stb_cycles;
        repeat (5) @(negedge clk);
        check("t6_no_more_stb", 64'(stb_cycles - sb), 64'd0);

        // Recovery: a fresh one-beat fill works after the reset
        wb = wa_q.size();
        start_cmd(1'b1, 64'h300, 16'd1, 64'h7, 3'd0);
        wait_done(cyc);
        repeat (2) @(negedge clk);
        check("t6_recover_n", 64'(wa_q.size() - wb), 64'd1);
        check("t6_recover_data", wd_q[wb], 64'h7);
        check("t6_recover_beats", 64'(beats), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
